fifo_write_arbiter: RTL and testbench

- Shares one fifo write port between NUM_REQ producers (step generators, host command parser) using round-robin arbitration with bounded bursts.
- Keeps its own credit count of free fifo slots, so it never overflows the fifo even though the fifo write is registered one cycle behind the grant.
- Sits directly in front of a fifo instance (dp_ram-backed) and drives that fifo's write/write_data pins.

---
 rtl/fifo_write_arbiter_pkg.sv | 24 ++
 rtl/fifo_write_arbiter_rr_pick.sv | 36 +++
 rtl/fifo_write_arbiter.sv | 106 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared types and constants for the fifo write-port arbiter.
package fifo_write_arbiter_pkg;

  localparam int DEF_NUM_REQ       = 4;
  localparam int DEF_ADDRESS_WIDTH = 4;
  localparam int CREDIT_WIDTH      = DEF_ADDRESS_WIDTH + 1;
  localparam int OWNER_WIDTH       = $clog2(DEF_NUM_REQ);
  localparam int BURST_WIDTH       = 4;

  // Net effect of one clock edge on the free-slot credit counter.
  typedef enum logic [1:0] {
    CRED_HOLD,
    CRED_TAKE,
    CRED_RETURN
  } credit_op_e;

  // A transfer claims a slot, a real fifo read frees one; both together cancel.
  function automatic credit_op_e credit_op(input logic xfer, input logic consumed);
    if (xfer && !consumed) return CRED_TAKE;
    if (consumed && !xfer) return CRED_RETURN;
    return CRED_HOLD;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index at or after start.
module fifo_write_arbiter_rr_pick
  import fifo_write_arbiter_pkg::*;
#(
  parameter int N  = DEF_NUM_REQ,
  parameter int IW = OWNER_WIDTH
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  localparam int unsigned NU = N;

  // Scan offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    int unsigned cand;
    cand  = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int unsigned k = 0; k < NU; k++) begin
      cand = 32'(start) + (NU - 1 - k);
      if (cand >= NU) cand = cand - NU;
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = IW'(cand);
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter sharing one fifo write port, with a
// credit counter that keeps the registered write from overflowing the fifo.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = CREDIT_WIDTH - 1,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_BURST     = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          fifo_write,
  output logic [DATA_WIDTH-1:0]         fifo_write_data,
  input  logic                          fifo_read,
  input  logic                          fifo_empty,
  output logic [ADDRESS_WIDTH:0]        credits,
  output logic [$clog2(NUM_REQ)-1:0]    owner
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = ADDRESS_WIDTH + 1;
  localparam logic [CW-1:0]          FULL_CREDITS = CW'(FIFO_DEPTH);
  localparam logic [BURST_WIDTH-1:0] BURST_LIMIT  = BURST_WIDTH'(MAX_BURST);
  localparam logic [OW-1:0]          LAST_IDX     = OW'(NUM_REQ - 1);

  logic [BURST_WIDTH-1:0] burst_cnt;
  logic [OW-1:0]          start_idx;
  logic [OW-1:0]          pick_idx;
  logic [OW-1:0]          sel_idx;
  logic [NUM_REQ-1:0]     pick_onehot;
  logic                   pick_any;
  logic                   hold;
  logic                   grant_ok;
  logic                   xfer;
  logic                   consumed;
  logic [DATA_WIDTH-1:0]  sel_data;
  credit_op_e             cred_op;

  assign start_idx = (owner == LAST_IDX) ? '0 : owner + 1'b1;

  fifo_write_arbiter_rr_pick #(
    .N  (NUM_REQ),
    .IW (OW)
  ) u_rr_pick (
    .req   (req),
    .start (start_idx),
    .grant (pick_onehot),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant selection: keep the owner within its burst, else rotate; reset forces ack low.
  always_comb begin
    hold     = req[owner] && (burst_cnt < BURST_LIMIT);
    grant_ok = reset && enable && (credits != '0) && pick_any;
    sel_idx  = hold ? owner : pick_idx;
    ack      = '0;
    if (grant_ok) begin
      if (hold) ack[owner] = 1'b1;
      else      ack        = pick_onehot;
    end
    xfer     = |(req & ack);
    consumed = fifo_read && !fifo_empty;
    sel_data = req_data[sel_idx*DATA_WIDTH +: DATA_WIDTH];
    cred_op  = credit_op(xfer, consumed);
  end

  // Registered fifo write, owner tracking and burst counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_write      <= 1'b0;
      fifo_write_data <= '0;
      owner           <= '0;
      burst_cnt       <= '0;
    end else if (xfer) begin
      fifo_write      <= 1'b1;
      fifo_write_data <= sel_data;
      owner           <= sel_idx;
      // A sole requester re-granted after an exhausted burst also restarts at 1.
      burst_cnt       <= hold ? burst_cnt + 1'b1 : BURST_WIDTH'(1);
    end else begin
      fifo_write <= 1'b0;
      if (!req[owner]) burst_cnt <= '0;
    end
  end

  // Free-slot credits: claimed at grant, returned when the consumer really reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      credits <= FULL_CREDITS;
    end else begin
      unique case (cred_op)
        CRED_TAKE:   credits <= credits - 1'b1;
        CRED_RETURN: if (credits != FULL_CREDITS) credits <= credits + 1'b1;
        default:     credits <= credits;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomised scoreboard bench for fifo_write_arbiter with a behavioural model.
module tb_fifo_write_arbiter;
  import fifo_write_arbiter_pkg::*;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int MB    = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    ack;
  logic            fifo_write;
  logic [DW-1:0]   fifo_write_data;
  logic            fifo_read = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [AW:0]     credits;
  logic [$clog2(N)-1:0] owner;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_q[$];

  // Reference model state
  int            m_owner = 0;
  int            m_burst = 0;
  int            m_cred  = DEPTH;
  int            m_cnt   = 0;   // words actually in the fifo
  bit            m_pend  = 0;   // write registered but not yet in the fifo
  logic [DW-1:0] word[N];
  int            emp_mode = 0;  // 0 real flag, 1 forced not-empty, 2 forced empty
  int            ack0_seen = 0;

  always #5 clk = ~clk;

  fifo_write_arbiter #(
    .NUM_REQ       (N),
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .FIFO_DEPTH    (DEPTH),
    .MAX_BURST     (MB)
  ) dut (
    .clk             (clk),
    .reset           (rst_n),
    .enable          (enable),
    .req             (req),
    .req_data        (req_data),
    .ack             (ack),
    .fifo_write      (fifo_write),
    .fifo_write_data (fifo_write_data),
    .fifo_read       (fifo_read),
    .fifo_empty      (fifo_empty),
    .credits         (credits),
    .owner           (owner)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Round-robin with bounded bursts, straight from the arbitration rules.
  function automatic int model_grant(input logic [N-1:0] r, input bit en);
    if (!en || m_cred == 0 || r == '0) return -1;
    if (r[m_owner] && m_burst < MB) return m_owner;
    for (int i = 1; i <= N; i++)
      if (r[(m_owner + i) % N]) return (m_owner + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = 0; m_burst = 0; m_cred = DEPTH; m_cnt = 0; m_pend = 0;
    exp_q.delete();
  endtask

  // One clock: drive at negedge, compare mid-cycle, advance model at posedge.
  task automatic step(input logic [N-1:0] r, input bit en, input bit rd, output int g);
    logic [N-1:0] exp_ack;
    bit cons;
    @(negedge clk);
    req = r;
    enable = en;
    fifo_read = rd;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = word[i];
    fifo_empty = (emp_mode == 1) ? 1'b0 : (emp_mode == 2) ? 1'b1 : (m_cnt == 0);
    #1;
    g = model_grant(r, en);
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    check("ack", 32'(ack), 32'(exp_ack));
    check("credits", 32'(credits), m_cred);
    check("owner", 32'(owner), m_owner);
    if (ack[0] === 1'b1) ack0_seen++;
    cons = rd && !fifo_empty;
    @(posedge clk);
    if (g >= 0) begin
      exp_q.push_back(word[g]);
      if (g == m_owner && m_burst < MB) m_burst++;
      else m_burst = 1;
      m_owner = g;
    end else if (!r[m_owner]) begin
      m_burst = 0;
    end
    if (g >= 0 && !cons) m_cred--;
    else if (cons && g < 0 && m_cred < DEPTH) m_cred++;
    if (cons && m_cnt > 0) m_cnt--;
    m_cnt += int'(m_pend);
    m_pend = (g >= 0);
  endtask

  // Monitor: every registered write must match the oldest granted word.
  always @(negedge clk) begin : monitor
    logic [DW-1:0] e;
    if (rst_n === 1'b1 && fifo_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL wdata: unexpected write of %0d, expected no write", fifo_write_data);
      end else begin
        e = exp_q.pop_front();
        check("wdata", 32'(fifo_write_data), 32'(e));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin : stim
    int g;
    int got0;
    logic [N-1:0] r;
    bit en, rd;
    for (int i = 0; i < N; i++) word[i] = '0;

    // Reset values
    #7;
    check("rst_write", 32'(fifo_write), 0);
    check("rst_wdata", 32'(fifo_write_data), 0);
    check("rst_credits", 32'(credits), DEPTH);
    check("rst_owner", 32'(owner), 0);
    check("rst_ack", 32'(ack), 0);
    #5 rst_n = 1'b1;

    // Single requester fills the fifo, then one read lets word 17 in
    word[0] = 8'd1;
    ack0_seen = 0;
    for (int c = 0; c < 24; c++) begin
      step(4'b0001, 1'b1, 1'b0, g);
      if (g == 0) word[0] = word[0] + 1'b1;
    end
    check("fill_acks", ack0_seen, 16);
    #1 check("full_credits", 32'(credits), 0);
    got0 = 0;
    step(4'b0001, 1'b1, 1'b1, g);
    for (int c = 0; c < 3; c++) begin
      step(4'b0001, 1'b1, 1'b0, g);
      if (g == 0) begin got0++; word[0] = word[0] + 1'b1; end
    end
    check("refill_one", got0, 1);

    // All four request while the consumer drains every cycle
    for (int c = 0; c < 40; c++) begin
      step(4'b1111, 1'b1, 1'b1, g);
      if (g >= 0) word[g] = DW'($urandom);
    end

    // Read with a forced empty flag must not return credits
    emp_mode = 2;
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1, 1'b1, g);
    emp_mode = 0;

    // Pause a burst on requester 1 with enable low
    for (int c = 0; c < 2; c++) begin
      step(4'b0010, 1'b1, 1'b1, g);
      if (g >= 0) word[g] = DW'($urandom);
    end
    for (int c = 0; c < 3; c++) step(4'b0010, 1'b0, 1'b1, g);
    for (int c = 0; c < 3; c++) begin
      step(4'b0010, 1'b1, 1'b1, g);
      if (g >= 0) word[g] = DW'($urandom);
    end

    // Requester 0 withdraws after two words while requester 2 waits
    got0 = 0;
    for (int c = 0; c < 8 && got0 < 2; c++) begin
      step(4'b0101, 1'b1, 1'b1, g);
      if (g >= 0) word[g] = DW'($urandom);
      if (g == 0) got0++;
    end
    for (int c = 0; c < 3; c++) begin
      step(4'b0100, 1'b1, 1'b1, g);
      if (g >= 0) word[g] = DW'($urandom);
    end

    // Random traffic with withdrawals, pauses and a mid-run reset
    r = '0;
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      rd = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(r, en, rd, g);
      for (int i = 0; i < N; i++) begin
        if (g == i) begin
          word[i] = DW'($urandom);
          r[i] = ($urandom_range(0, 3) != 0);
        end else if (r[i]) begin
          r[i] = ($urandom_range(0, 15) != 0);
        end else if ($urandom_range(0, 2) == 0) begin
          r[i] = 1'b1;
          word[i] = DW'($urandom);
        end
      end
      if (c == 250) begin
        #2;
        check("pre_rst_write", 32'(fifo_write), 32'(m_pend));
        rst_n = 1'b0;
        #1;
        check("arst_write", 32'(fifo_write), 0);
        check("arst_credits", 32'(credits), DEPTH);
        check("arst_owner", 32'(owner), 0);
        check("arst_ack", 32'(ack), 0);
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end

    // Drain, then fake reads past full to probe credit saturation
    for (int c = 0; c < 40 && m_cnt + int'(m_pend) > 0; c++) step(4'b0000, 1'b1, 1'b1, g);
    emp_mode = 1;
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1, 1'b1, g);
    emp_mode = 0;
    for (int c = 0; c < 3; c++) step(4'b0000, 1'b1, 1'b0, g);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
